// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for drivers of the 35-bit core instruction word.
//   - sequencer state encodings (legacy-compatible 4-bit constants)
//   - instruction word bit positions and the idle word
//   - inst_fields_t: unpacked view of the instruction word, and the
//     field set that packs to the idle word
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

   localparam int INST_W = 35;
   localparam int ADDR_W = 11;
   localparam int CNT_W  = 7;

   // Instruction word layout:
   // {mode,acc,CEN_p,WEN_p,A_p[10:0],CEN_x,WEN_x,A_x[10:0],
   //  ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}
   localparam int B_MODE     = 34;
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_AP_LSB   = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_AX_LSB   = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   // Both SRAMs deselected (CEN/WEN high), every other field zero.
   localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE   = 4'd0;
   localparam state_t S_CLR    = 4'd1;
   localparam state_t S_W_RD   = 4'd2;
   localparam state_t S_G_W    = 4'd3;   // gap after kernel read
   localparam state_t S_W_LOAD = 4'd4;
   localparam state_t S_G_L    = 4'd5;   // gap after kernel load
   localparam state_t S_X_RD   = 4'd6;
   localparam state_t S_G_X    = 4'd7;   // gap after activation read
   localparam state_t S_EXEC   = 4'd8;
   localparam state_t S_DRAIN  = 4'd9;
   localparam state_t S_G_D    = 4'd10;  // gap after drain
   localparam state_t S_OF_RD  = 4'd11;
   localparam state_t S_FIN    = 4'd12;

   typedef struct packed {
      logic              mode;
      logic              acc;
      logic              cen_p;
      logic              wen_p;
      logic [ADDR_W-1:0] a_p;
      logic              cen_x;
      logic              wen_x;
      logic [ADDR_W-1:0] a_x;
      logic              ofifo_rd;
      logic              ififo_wr;
      logic              ififo_rd;
      logic              l0_rd;
      logic              l0_wr;
      logic              execute;
      logic              load;
   } inst_fields_t;

   function automatic inst_fields_t idle_fields();
      inst_fields_t f;
      f       = '0;
      f.cen_p = 1'b1;
      f.wen_p = 1'b1;
      f.cen_x = 1'b1;
      f.wen_x = 1'b1;
      return f;
   endfunction

endpackage

// File: rtl/core_pass_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_pass_sequencer_if
// Host/core side signals of the pass sequencer.
//   start       host -> seq   1-cycle start pulse
//   os_mode     host -> seq   1 = output-stationary, 0 = weight-stationary
//   n_kij       host -> seq   number of kij passes (0 or too large = max)
//   ofifo_valid core -> seq   OFIFO has a readable word
//   inst        seq  -> core  35-bit core instruction word
//   core_clr    seq  -> core  core/array clear
//   busy        seq  -> host  sequence in progress
//   done        seq  -> host  1-cycle pulse when all passes are in pmem
//   cur_kij     seq  -> host  index of pass in progress
// master = host/core environment, slave = sequencer.
// ---------------------------------------------------------------------------
interface core_pass_sequencer_if;
   import core_ctrl_pkg::*;

   logic              start;
   logic              os_mode;
   logic [3:0]        n_kij;
   logic              ofifo_valid;
   logic [INST_W-1:0] inst;
   logic              core_clr;
   logic              busy;
   logic              done;
   logic [3:0]        cur_kij;

   modport master (
      output start, os_mode, n_kij, ofifo_valid,
      input  inst, core_clr, busy, done, cur_kij
   );

   modport slave (
      input  start, os_mode, n_kij, ofifo_valid,
      output inst, core_clr, busy, done, cur_kij
   );

endinterface

// File: rtl/core_inst_pack.sv
// ---------------------------------------------------------------------------
// core_inst_pack
// Combinational packer: instruction fields -> 35-bit core instruction word.
//   f     in   inst_fields_t  field view of the instruction
//   inst  out  35            packed instruction word
// ---------------------------------------------------------------------------
module core_inst_pack
   import core_ctrl_pkg::*;
(
   input  inst_fields_t      f,
   output logic [INST_W-1:0] inst
);

   always_comb begin
      inst                        = '0;
      inst[B_MODE]                = f.mode;
      inst[B_ACC]                 = f.acc;
      inst[B_CEN_P]               = f.cen_p;
      inst[B_WEN_P]               = f.wen_p;
      inst[B_AP_LSB +: ADDR_W]    = f.a_p;
      inst[B_CEN_X]               = f.cen_x;
      inst[B_WEN_X]               = f.wen_x;
      inst[B_AX_LSB +: ADDR_W]    = f.a_x;
      inst[B_OFIFO_RD]            = f.ofifo_rd;
      inst[B_IFIFO_WR]            = f.ififo_wr;
      inst[B_IFIFO_RD]            = f.ififo_rd;
      inst[B_L0_RD]               = f.l0_rd;
      inst[B_L0_WR]               = f.l0_wr;
      inst[B_EXEC]                = f.execute;
      inst[B_LOAD]                = f.load;
   end

endmodule

// File: rtl/core_pass_sequencer.sv
// ---------------------------------------------------------------------------
// core_pass_sequencer
// Generates the core instruction stream for a full conv schedule. Each kij
// pass: clear core, kernel xmem->L0, L0->PEs, activations xmem->L0, execute,
// drain, then move OFIFO words to pmem (pass k at P_BASE + k*LEN_NIJ).
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-high reset, aborts to IDLE
//   bus    slave modport of core_pass_sequencer_if
//          (start/os_mode/n_kij/ofifo_valid in; inst/core_clr/busy/done/
//           cur_kij out, all registered)
// Every output is decoded from the current state and registered, so a
// state's instruction appears one cycle after the state is entered.
// ---------------------------------------------------------------------------
module core_pass_sequencer
   import core_ctrl_pkg::*;
#(
   parameter int              COL     = 8,
   parameter int              ROW     = 8,
   parameter int              LEN_NIJ = 36,
   parameter int              MAX_KIJ = 9,
   parameter logic [ADDR_W-1:0] W_BASE = 11'h400,
   parameter logic [ADDR_W-1:0] X_BASE = 11'h000,
   parameter logic [ADDR_W-1:0] P_BASE = 11'h000,
   parameter int              CLR_CYC = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   core_pass_sequencer_if.slave  bus
);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [3:0]         kij;
   logic [3:0]         n_pass;
   logic               os_r;
   logic               wr_pend;

   logic               phase_end;
   logic               rd_ok;
   logic               pass_end;
   logic               last_pass;

   inst_fields_t       fields_p0;
   logic [INST_W-1:0]  inst_p0;
   logic               clr_p0, busy_p0, done_p0;

   logic [INST_W-1:0]  inst_p1;
   logic               clr_p1, busy_p1, done_p1;
   logic [3:0]         cur_kij_p1;

   function automatic logic [CNT_W-1:0] phase_len(input state_t s);
      case (s)
         S_CLR:            return CNT_W'(CLR_CYC);
         S_W_RD, S_W_LOAD: return CNT_W'(COL);
         S_X_RD:           return CNT_W'(LEN_NIJ);
         S_EXEC:           return CNT_W'(LEN_NIJ + ROW + COL);
         S_DRAIN:          return CNT_W'(ROW + 2);
         default:          return CNT_W'(1);
      endcase
   endfunction

   // 11-bit address arithmetic; wraps mod 2048 by construction.
   function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                 input logic [3:0]        pass,
                                                 input int                stride,
                                                 input logic [CNT_W-1:0]  idx);
      return base + ADDR_W'(pass) * ADDR_W'(stride) + ADDR_W'(idx);
   endfunction

   function automatic logic [3:0] clamp_passes(input logic [3:0] n);
      if (n == 4'd0 || int'(n) > MAX_KIJ)
         return 4'(MAX_KIJ);
      return n;
   endfunction

   assign phase_end = (cnt == phase_len(state) - CNT_W'(1));
   // In OF_RD cnt counts accepted reads; writes trail reads by one cycle.
   assign rd_ok     = (state == S_OF_RD) && bus.ofifo_valid && (cnt < CNT_W'(LEN_NIJ));
   assign pass_end  = wr_pend && (cnt == CNT_W'(LEN_NIJ));
   assign last_pass = (kij == n_pass - 4'd1);

   always_comb begin
      state_n = state;
      cnt_n   = phase_end ? '0 : cnt + CNT_W'(1);
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (bus.start)
               state_n = S_CLR;
         end
         S_CLR:    if (phase_end) state_n = S_W_RD;
         S_W_RD:   if (phase_end) state_n = S_G_W;
         S_G_W:    state_n = S_W_LOAD;
         S_W_LOAD: if (phase_end) state_n = S_G_L;
         S_G_L:    state_n = S_X_RD;
         S_X_RD:   if (phase_end) state_n = S_G_X;
         S_G_X:    state_n = S_EXEC;
         S_EXEC:   if (phase_end) state_n = S_DRAIN;
         S_DRAIN:  if (phase_end) state_n = S_G_D;
         S_G_D:    state_n = S_OF_RD;
         S_OF_RD: begin
            cnt_n = rd_ok ? cnt + CNT_W'(1) : cnt;
            if (pass_end) begin
               cnt_n   = '0;
               state_n = last_pass ? S_FIN : S_CLR;
            end
         end
         S_FIN: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         kij     <= '0;
         n_pass  <= '0;
         os_r    <= 1'b0;
         wr_pend <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         wr_pend <= rd_ok;
         if (state == S_IDLE && bus.start) begin
            kij    <= '0;
            n_pass <= clamp_passes(bus.n_kij);
            os_r   <= bus.os_mode;
         end else if (state == S_OF_RD && pass_end && !last_pass) begin
            kij <= kij + 4'd1;
         end else if (state == S_FIN) begin
            kij <= '0;
         end
      end
   end

   // ---- stage p0: decode current state into instruction fields ----
   always_comb begin
      fields_p0 = idle_fields();
      clr_p0    = 1'b0;
      busy_p0   = (state != S_IDLE);
      done_p0   = 1'b0;
      case (state)
         S_CLR: clr_p0 = 1'b1;
         S_W_RD: begin
            fields_p0.cen_x = 1'b0;
            fields_p0.a_x   = addr_at(W_BASE, kij, COL, cnt);
            // L0 write trails the SRAM read by one cycle.
            fields_p0.l0_wr = (cnt != '0);
         end
         S_G_W: fields_p0.l0_wr = 1'b1;
         S_W_LOAD: begin
            fields_p0.mode  = os_r;
            fields_p0.l0_rd = 1'b1;
            fields_p0.load  = 1'b1;
         end
         S_G_L: fields_p0.mode = os_r;
         S_X_RD: begin
            fields_p0.mode  = os_r;
            fields_p0.cen_x = 1'b0;
            fields_p0.a_x   = addr_at(X_BASE, 4'd0, 0, cnt);
            fields_p0.l0_wr = (cnt != '0);
         end
         S_G_X: begin
            fields_p0.mode  = os_r;
            fields_p0.l0_wr = 1'b1;
         end
         S_EXEC: begin
            fields_p0.mode    = os_r;
            fields_p0.l0_rd   = 1'b1;
            fields_p0.execute = 1'b1;
         end
         S_DRAIN: fields_p0.execute = 1'b1;
         S_OF_RD: begin
            fields_p0.ofifo_rd = rd_ok;
            if (wr_pend) begin
               fields_p0.cen_p = 1'b0;
               fields_p0.wen_p = 1'b0;
               fields_p0.a_p   = addr_at(P_BASE, kij, LEN_NIJ, cnt - CNT_W'(1));
            end
         end
         S_FIN: done_p0 = 1'b1;
         default: ;
      endcase
   end

   core_inst_pack u_pack (
      .f    (fields_p0),
      .inst (inst_p0)
   );

   // ---- stage p1: registered outputs ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_p1    <= INST_IDLE;
         clr_p1     <= 1'b0;
         busy_p1    <= 1'b0;
         done_p1    <= 1'b0;
         cur_kij_p1 <= '0;
      end else begin
         inst_p1    <= inst_p0;
         clr_p1     <= clr_p0;
         busy_p1    <= busy_p0;
         done_p1    <= done_p0;
         cur_kij_p1 <= kij;
      end
   end

   assign bus.inst     = inst_p1;
   assign bus.core_clr = clr_p1;
   assign bus.busy     = busy_p1;
   assign bus.done     = done_p1;
   assign bus.cur_kij  = cur_kij_p1;

endmodule
